// File: rtl/nop_run_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : nop_run_monitor
//  Description : Watches one pipeline stage's instruction stream, one word per
//                cycle, qualified by i_valid. Each valid word is classified as
//                NOP / non-NOP with a mask/match pair. The block tracks the
//                current consecutive-NOP run and a saturating total NOP count.
//                It reports "drained" once RUN_THRESHOLD consecutive NOPs have
//                been seen.
//  Ports       : i_clk            - clock, rising edge
//                i_reset          - synchronous reset, active-high
//                i_clear          - synchronous clear of counters and flags
//                i_valid          - i_instr is meaningful this cycle
//                i_instr          - instruction word under test
//                o_is_nop         - last accepted word was a NOP
//                o_run_len        - current consecutive-NOP run (saturating)
//                o_nop_count      - total NOPs since reset/clear (saturating)
//                o_drained        - high while in the DRAINED state
//                o_drained_pulse  - one-cycle pulse on entry to DRAINED
//                o_sat            - sticky, total count has reached all-ones
//  Revision    : 1.0 - initial release
// ============================================================================
module nop_run_monitor #(
    parameter int                    DATA_LEN      = 32,
    parameter int                    CNT_LEN       = 16,
    parameter int                    RUN_THRESHOLD = 5,
    parameter logic [DATA_LEN-1:0]   NOP_MASK      = {DATA_LEN{1'b1}},
    parameter logic [DATA_LEN-1:0]   NOP_MATCH     = {DATA_LEN{1'b0}}
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_clear,
    input  logic                i_valid,
    input  logic [DATA_LEN-1:0] i_instr,
    output logic                o_is_nop,
    output logic [CNT_LEN-1:0]  o_run_len,
    output logic [CNT_LEN-1:0]  o_nop_count,
    output logic                o_drained,
    output logic                o_drained_pulse,
    output logic                o_sat
);

    localparam logic [CNT_LEN-1:0] c_cnt_max   = {CNT_LEN{1'b1}};
    localparam logic [CNT_LEN-1:0] c_threshold = CNT_LEN'(RUN_THRESHOLD);

    typedef enum logic [1:0] {
        ST_ACTIVE  = 2'd0,
        ST_RUN     = 2'd1,
        ST_DRAINED = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_is_nop;
    logic [CNT_LEN-1:0]   r_run_len;
    logic [CNT_LEN-1:0]   r_nop_count;
    logic                 r_drained;
    logic                 r_drained_pulse;
    logic                 r_sat;

    logic                 w_is_nop;
    logic [CNT_LEN-1:0]   w_run_inc;
    logic [CNT_LEN-1:0]   w_cnt_inc;

    // Only the masked bits take part in the comparison.
    assign w_is_nop  = ((i_instr & NOP_MASK) == (NOP_MATCH & NOP_MASK));

    // Saturating increments of both counters.
    assign w_run_inc = (r_run_len == c_cnt_max)   ? r_run_len   : r_run_len   + CNT_LEN'(1);
    assign w_cnt_inc = (r_nop_count == c_cnt_max) ? r_nop_count : r_nop_count + CNT_LEN'(1);

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            // Clear shares reset's effect and beats i_valid, so a word
            // presented alongside it is dropped and no pulse is produced.
            r_state         <= ST_ACTIVE;
            r_is_nop        <= 1'b0;
            r_run_len       <= '0;
            r_nop_count     <= '0;
            r_drained       <= 1'b0;
            r_drained_pulse <= 1'b0;
            r_sat           <= 1'b0;
        end else begin
            r_drained_pulse <= 1'b0;
            if (i_valid) begin
                r_is_nop <= w_is_nop;
                if (w_is_nop) begin
                    r_run_len   <= w_run_inc;
                    r_nop_count <= w_cnt_inc;
                    if (w_cnt_inc == c_cnt_max) begin
                        r_sat <= 1'b1;
                    end
                    case (r_state)
                        ST_ACTIVE, ST_RUN: begin
                            // Entry test uses the post-increment run, which
                            // covers RUN_THRESHOLD=1 straight from ACTIVE.
                            if (w_run_inc == c_threshold) begin
                                r_state         <= ST_DRAINED;
                                r_drained       <= 1'b1;
                                r_drained_pulse <= 1'b1;
                            end else begin
                                r_state <= ST_RUN;
                            end
                        end
                        ST_DRAINED: begin
                            // Stay drained; run saturation has no effect here.
                            r_state <= ST_DRAINED;
                        end
                        default: begin
                            r_state   <= ST_ACTIVE;
                            r_drained <= 1'b0;
                        end
                    endcase
                end else begin
                    r_run_len <= '0;
                    r_state   <= ST_ACTIVE;
                    r_drained <= 1'b0;
                end
            end
        end
    end

    assign o_is_nop        = r_is_nop;
    assign o_run_len       = r_run_len;
    assign o_nop_count     = r_nop_count;
    assign o_drained       = r_drained;
    assign o_drained_pulse = r_drained_pulse;
    assign o_sat           = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_nop_run_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nop_run_monitor
//  Description : Self-checking bench for nop_run_monitor. Two instances share
//                one stimulus stream: a default one (full mask, 16-bit
//                counters) and a narrow one (partial mask, 4-bit counters) so
//                that masking and saturation are exercised. Expected values
//                come from a streak/total reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nop_run_monitor;

    localparam int          c_th     = 5;
    localparam logic [31:0] c_mask_b = 32'hFC00003F;

    logic        clk = 1'b0;
    logic        reset, clear, valid;
    logic [31:0] instr;

    logic        a_is_nop, a_drained, a_pulse, a_sat;
    logic [15:0] a_run, a_cnt;
    logic        b_is_nop, b_drained, b_pulse, b_sat;
    logic [3:0]  b_run, b_cnt;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state, index 0 = default instance, 1 = narrow instance.
    int          streak [2];
    int          total  [2];
    bit          last_nop [2];
    bit          pulse  [2];
    int          cmax   [2];
    logic [31:0] mask   [2];

    always #5 clk = ~clk;

    nop_run_monitor dut_a (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_clear         (clear),
        .i_valid         (valid),
        .i_instr         (instr),
        .o_is_nop        (a_is_nop),
        .o_run_len       (a_run),
        .o_nop_count     (a_cnt),
        .o_drained       (a_drained),
        .o_drained_pulse (a_pulse),
        .o_sat           (a_sat)
    );

    nop_run_monitor #(
        .CNT_LEN   (4),
        .NOP_MASK  (c_mask_b),
        .NOP_MATCH (32'h0)
    ) dut_b (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_clear         (clear),
        .i_valid         (valid),
        .i_instr         (instr),
        .o_is_nop        (b_is_nop),
        .o_run_len       (b_run),
        .o_nop_count     (b_cnt),
        .o_drained       (b_drained),
        .o_drained_pulse (b_pulse),
        .o_sat           (b_sat)
    );

    function automatic int imin(input int x, input int y);
        return (x < y) ? x : y;
    endfunction

    // Streak is the unbounded count of NOPs since the last non-NOP/clear;
    // drained simply means the streak has reached the threshold.
    task automatic model_step(input bit r, input bit c, input bit v, input logic [31:0] w);
        for (int d = 0; d < 2; d++) begin
            if (r || c) begin
                streak[d] = 0; total[d] = 0; last_nop[d] = 0; pulse[d] = 0;
            end else if (v) begin
                bit nop;
                bit was_drained;
                nop         = ((w & mask[d]) == 32'h0);
                was_drained = (streak[d] >= c_th);
                last_nop[d] = nop;
                if (nop) begin
                    streak[d]++;
                    total[d]++;
                end else begin
                    streak[d] = 0;
                end
                pulse[d] = (streak[d] >= c_th) && !was_drained;
            end else begin
                pulse[d] = 0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("a_is_nop",  32'(a_is_nop),  32'(last_nop[0]));
        check("a_run",     32'(a_run),     32'(imin(streak[0], cmax[0])));
        check("a_count",   32'(a_cnt),     32'(imin(total[0], cmax[0])));
        check("a_drained", 32'(a_drained), 32'(streak[0] >= c_th));
        check("a_pulse",   32'(a_pulse),   32'(pulse[0]));
        check("a_sat",     32'(a_sat),     32'(total[0] >= cmax[0]));
        check("b_is_nop",  32'(b_is_nop),  32'(last_nop[1]));
        check("b_run",     32'(b_run),     32'(imin(streak[1], cmax[1])));
        check("b_count",   32'(b_cnt),     32'(imin(total[1], cmax[1])));
        check("b_drained", 32'(b_drained), 32'(streak[1] >= c_th));
        check("b_pulse",   32'(b_pulse),   32'(pulse[1]));
        check("b_sat",     32'(b_sat),     32'(total[1] >= cmax[1]));
    endtask

    // Inputs are driven 1 ns after an edge and checked 1 ns after the next.
    task automatic apply(input bit r, input bit c, input bit v, input logic [31:0] w);
        reset = r; clear = c; valid = v; instr = w;
        @(posedge clk);
        #1;
        model_step(r, c, v, w);
        check_all();
    endtask

    initial begin
        logic [31:0] pick;
        cmax[0] = 16'hFFFF; cmax[1] = 15;
        mask[0] = 32'hFFFFFFFF; mask[1] = c_mask_b;
        for (int d = 0; d < 2; d++) begin
            streak[d] = 0; total[d] = 0; last_nop[d] = 0; pulse[d] = 0;
        end
        reset = 1'b1; clear = 1'b0; valid = 1'b1; instr = 32'h0;

        // Reset held two cycles with a valid NOP presented.
        apply(1, 0, 1, 32'h0);
        apply(1, 0, 1, 32'h0);
        apply(0, 0, 0, 32'h0);

        // Drain at the default threshold, then one extra NOP.
        for (int i = 0; i < 6; i++) apply(0, 0, 1, 32'h0);
        apply(0, 0, 0, 32'h0);

        // Broken run.
        apply(0, 1, 0, 32'h0);
        apply(0, 0, 1, 32'h0);
        apply(0, 0, 1, 32'h0);
        apply(0, 0, 1, 32'h0);
        apply(0, 0, 1, 32'h00000001);
        apply(0, 0, 1, 32'h0);

        // Valid gaps.
        apply(0, 1, 0, 32'h0);
        for (int i = 0; i < 11; i++) apply(0, 0, (i % 2) == 0, 32'h0);

        // Masked NOP word (non-NOP for the full mask), then saturation.
        apply(0, 1, 0, 32'h0);
        apply(0, 0, 1, 32'h00421000);
        for (int i = 0; i < 17; i++) apply(0, 0, 1, 32'h00421000);
        apply(0, 1, 0, 32'h0);

        // Clear while drained, together with a NOP, then re-drain.
        for (int i = 0; i < 6; i++) apply(0, 0, 1, 32'h0);
        apply(0, 1, 1, 32'h0);
        for (int i = 0; i < 6; i++) apply(0, 0, 1, 32'h0);
        // Same sequence using reset.
        apply(1, 0, 1, 32'h0);
        for (int i = 0; i < 6; i++) apply(0, 0, 1, 32'h0);

        // Randomized traffic biased toward NOP runs.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: pick = 32'h0;
                3:       pick = 32'h00421000;
                4:       pick = 32'h00000001;
                default: pick = $urandom;
            endcase
            apply(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 3) != 0),
                  pick);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
